fx2_slave_fifo: RTL and testbench
=================================

FX2_SLAVE_FIFO -- requirements
Module: fx2_slave_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning the byte capacity of each endpoint FIFO.
REQ-002 SHALL have parameter PTR_W, default 9, meaning the pointer width; DEPTH = 2^PTR_W.
REQ-003 SHALL have port usb_ifclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port usb_addr, input, 2 bits: endpoint select; 00=EP2, 01=EP4, 10=EP6, 11=EP8.
REQ-006 SHALL have port usb_slrd, input, 1 bit: active-high read strobe from FPGA.
REQ-007 SHALL have port usb_slwr, input, 1 bit: active-high write strobe from FPGA.
REQ-008 SHALL have port usb_sloe, input, 1 bit: active-high output enable for usb_data_in.
REQ-009 SHALL have port usb_data_out, input, 8 bits: byte written by the FPGA to EP6/EP8.
REQ-010 SHALL have port usb_data_in, output, 8 bits: byte presented to the FPGA from EP2/EP4.
REQ-011 SHALL have ports usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full, output, 1 bit each: active-high endpoint flags.
REQ-012 SHALL have ports host_ep2_data and host_ep4_data (input, 8 bits), host_ep2_valid and host_ep4_valid (input, 1 bit), and host_ep2_ready and host_ep4_ready (output, 1 bit): the host-side OUT-endpoint push streams.
REQ-013 SHALL have ports host_ep6_data and host_ep8_data (output, 8 bits), host_ep6_valid and host_ep8_valid (output, 1 bit), and host_ep6_ready and host_ep8_ready (input, 1 bit): the host-side IN-endpoint pop streams.
REQ-014 SHALL have ports err_underflow, err_overflow and err_protocol, output, 1 bit each: sticky error flags.

Function
REQ-015 SHALL contain four independent FIFOs of DEPTH bytes, each with a PTR_W-bit read pointer, a PTR_W-bit write pointer and a (PTR_W+1)-bit occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-016 Host push SHALL occur when host_epN_valid & host_epN_ready; host_epN_ready = (count < DEPTH) for N in {2,4}.
REQ-017 Host pop SHALL occur when host_epN_valid & host_epN_ready for N in {6,8}; host_epN_valid = (count != 0); host_epN_data = FIFO head (first-word fall-through).
REQ-018 usb_data_in SHALL equal the head byte of the addressed FIFO, combinationally, when usb_sloe=1 and usb_addr is 00 or 01; otherwise it SHALL be 8'h00.
REQ-019 usb_slrd=1 with usb_addr 00/01 and that FIFO non-empty SHALL pop one byte at the edge; the new head appears on usb_data_in the following cycle.
REQ-020 usb_slwr=1 with usb_addr 10/11 and that FIFO not full SHALL write usb_data_out at the edge.
REQ-021 usb_slrd on an empty EP2/EP4 SHALL be ignored and SHALL set err_underflow.
REQ-022 usb_slwr on a full EP6/EP8 SHALL drop the byte and SHALL set err_overflow.
REQ-023 usb_slrd with usb_addr 10/11, or usb_slwr with usb_addr 00/01, SHALL be ignored and SHALL set err_protocol.
REQ-024 A simultaneous push and pop on one FIFO SHALL both take effect, leaving count unchanged; at count=0 only the push occurs, and at count=DEPTH only the pop occurs.
REQ-025 usb_ep2_empty/usb_ep4_empty SHALL equal (count==0) and usb_ep6_full/usb_ep8_full SHALL equal (count==DEPTH), derived from registered counts, so they reflect a transfer one cycle after its edge.
REQ-026 Error flags SHALL remain set until reset.

Reset
REQ-027 With reset=1 at an edge, all pointers and counts SHALL clear to 0 and all error flags to 0, discarding FIFO contents, regardless of concurrent strobes or host handshakes.
REQ-028 During and after reset: usb_ep2_empty=1, usb_ep4_empty=1, usb_ep6_full=0, usb_ep8_full=0, host_ep2_ready=1, host_ep4_ready=1, host_ep6_valid=0, host_ep8_valid=0, usb_data_in=8'h00.

Verification
REQ-029 Host pushes 8'hA5, 8'h3C to EP2; addr=00, sloe=1, slrd for 2 cycles -> usb_data_in reads A5 then 3C; usb_ep2_empty=1 the cycle after the second pop.
REQ-030 addr=10, slwr for 512 cycles with data 0..255 repeating, host_ep6_ready=0 -> usb_ep6_full=1 after the 512th write; a 513th write is dropped, err_overflow=1; the host then pops 512 bytes in order 0..255, 0..255.
REQ-031 slrd at addr=01 with EP4 empty -> no state change, err_underflow=1; slwr at addr=00 -> err_protocol=1.
REQ-032 EP8 at count=5: slwr and host pop in the same cycle -> count stays 5 and byte order is preserved.
REQ-033 Assert reset mid-burst with EP2 at count 100 and EP6 full -> next cycle usb_ep2_empty=1, usb_ep6_full=0, all error flags=0.

Source files
------------

// File: rtl/fx2_slave_fifo.sv
// fx2_slave_fifo: FX2-style slave FIFO with two OUT (EP2/EP4) and two IN (EP6/EP8) byte endpoints
module fx2_slave_fifo #(
  parameter int DEPTH = 512,
  parameter int PTR_W = 9
) (
  input  logic       usb_ifclk,
  input  logic       reset,
  input  logic [1:0] usb_addr,
  input  logic       usb_slrd,
  input  logic       usb_slwr,
  input  logic       usb_sloe,
  input  logic [7:0] usb_data_out,
  output logic [7:0] usb_data_in,
  output logic       usb_ep2_empty,
  output logic       usb_ep4_empty,
  output logic       usb_ep6_full,
  output logic       usb_ep8_full,
  input  logic [7:0] host_ep2_data,
  input  logic [7:0] host_ep4_data,
  input  logic       host_ep2_valid,
  input  logic       host_ep4_valid,
  output logic       host_ep2_ready,
  output logic       host_ep4_ready,
  output logic [7:0] host_ep6_data,
  output logic [7:0] host_ep8_data,
  output logic       host_ep6_valid,
  output logic       host_ep8_valid,
  input  logic       host_ep6_ready,
  input  logic       host_ep8_ready,
  output logic       err_underflow,
  output logic       err_overflow,
  output logic       err_protocol
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [7:0] head [4];
  logic [7:0] wdat [4];
  logic [3:0] push, pop, empty, full;
  logic rd_out, wr_in;
  // index 0..3 = EP2, EP4, EP6, EP8, matching usb_addr
  always_comb begin
    rd_out = usb_slrd & ~usb_addr[1];
    wr_in = usb_slwr & usb_addr[1];
    push[0] = host_ep2_valid & ~full[0];
    push[1] = host_ep4_valid & ~full[1];
    push[2] = wr_in & ~usb_addr[0] & ~full[2];
    push[3] = wr_in & usb_addr[0] & ~full[3];
    pop[0] = rd_out & ~usb_addr[0] & ~empty[0];
    pop[1] = rd_out & usb_addr[0] & ~empty[1];
    pop[2] = host_ep6_ready & ~empty[2];
    pop[3] = host_ep8_ready & ~empty[3];
    wdat[0] = host_ep2_data;
    wdat[1] = host_ep4_data;
    wdat[2] = usb_data_out;
    wdat[3] = usb_data_out;
  end
  for (genvar i = 0; i < 4; i++) begin : g_ep
    logic [7:0] mem [DEPTH];
    logic [PTR_W-1:0] rp, wp;
    logic [PTR_W:0] n;
    always_ff @(posedge usb_ifclk)
      if (push[i]) mem[wp] <= wdat[i];
    always_ff @(posedge usb_ifclk) begin
      if (reset) begin
        rp <= '0;
        wp <= '0;
        n <= '0;
      end else begin
        if (push[i]) wp <= wp + PTR_W'(1);
        if (pop[i]) rp <= rp + PTR_W'(1);
        n <= n + (PTR_W+1)'(push[i]) - (PTR_W+1)'(pop[i]);
      end
    end
    assign head[i] = mem[rp];
    assign empty[i] = n == '0;
    assign full[i] = n == FULL;
  end
  always_ff @(posedge usb_ifclk) begin
    if (reset) begin
      err_underflow <= 1'b0;
      err_overflow <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      err_underflow <= err_underflow | (rd_out & empty[usb_addr]);
      err_overflow <= err_overflow | (wr_in & full[usb_addr]);
      err_protocol <= err_protocol | (usb_slrd & usb_addr[1]) | (usb_slwr & ~usb_addr[1]);
    end
  end
  // an empty FIFO presents 8'h00 so stale RAM never leaks onto the bus
  assign usb_data_in = (usb_sloe & ~usb_addr[1] & ~empty[usb_addr]) ? head[usb_addr[0]] : 8'h00;
  assign usb_ep2_empty = empty[0];
  assign usb_ep4_empty = empty[1];
  assign usb_ep6_full = full[2];
  assign usb_ep8_full = full[3];
  assign host_ep2_ready = ~full[0];
  assign host_ep4_ready = ~full[1];
  assign host_ep6_valid = ~empty[2];
  assign host_ep8_valid = ~empty[3];
  assign host_ep6_data = head[2];
  assign host_ep8_data = head[3];
endmodule

// File: tb/tb_fx2_slave_fifo.sv
// tb_fx2_slave_fifo: randomized and directed checks of fx2_slave_fifo against a queue-based model
module tb_fx2_slave_fifo;
  localparam int DEPTH = 512;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] usb_addr;
  logic usb_slrd, usb_slwr, usb_sloe;
  logic [7:0] usb_data_out, usb_data_in;
  logic usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full;
  logic [7:0] host_ep2_data, host_ep4_data, host_ep6_data, host_ep8_data;
  logic host_ep2_valid, host_ep4_valid, host_ep2_ready, host_ep4_ready;
  logic host_ep6_valid, host_ep8_valid, host_ep6_ready, host_ep8_ready;
  logic err_underflow, err_overflow, err_protocol;
  int tests = 0, fails = 0;
  logic [7:0] q2[$], q4[$], q6[$], q8[$];
  bit m_uf, m_of, m_pr;

  always #5 clk = ~clk;

  fx2_slave_fifo dut (
    .usb_ifclk(clk), .reset(reset), .usb_addr(usb_addr), .usb_slrd(usb_slrd),
    .usb_slwr(usb_slwr), .usb_sloe(usb_sloe), .usb_data_out(usb_data_out),
    .usb_data_in(usb_data_in), .usb_ep2_empty(usb_ep2_empty), .usb_ep4_empty(usb_ep4_empty),
    .usb_ep6_full(usb_ep6_full), .usb_ep8_full(usb_ep8_full),
    .host_ep2_data(host_ep2_data), .host_ep4_data(host_ep4_data),
    .host_ep2_valid(host_ep2_valid), .host_ep4_valid(host_ep4_valid),
    .host_ep2_ready(host_ep2_ready), .host_ep4_ready(host_ep4_ready),
    .host_ep6_data(host_ep6_data), .host_ep8_data(host_ep8_data),
    .host_ep6_valid(host_ep6_valid), .host_ep8_valid(host_ep8_valid),
    .host_ep6_ready(host_ep6_ready), .host_ep8_ready(host_ep8_ready),
    .err_underflow(err_underflow), .err_overflow(err_overflow), .err_protocol(err_protocol)
  );

  task automatic idle();
    reset = 1'b0;
    usb_addr = 2'd0;
    usb_slrd = 1'b0;
    usb_slwr = 1'b0;
    usb_sloe = 1'b0;
    usb_data_out = 8'h00;
    host_ep2_data = 8'h00;
    host_ep4_data = 8'h00;
    host_ep2_valid = 1'b0;
    host_ep4_valid = 1'b0;
    host_ep6_ready = 1'b0;
    host_ep8_ready = 1'b0;
  endtask

  // advance one clock; the model applies the endpoint rules to the inputs held across the edge
  task automatic cycle();
    bit pu2, pu4, pu6, pu8, po2, po4, po6, po8, uf, of, pr, rst;
    logic [7:0] d2, d4, dw;
    pu2 = host_ep2_valid && q2.size() < DEPTH;
    pu4 = host_ep4_valid && q4.size() < DEPTH;
    pu6 = usb_slwr && usb_addr == 2'd2 && q6.size() < DEPTH;
    pu8 = usb_slwr && usb_addr == 2'd3 && q8.size() < DEPTH;
    po2 = usb_slrd && usb_addr == 2'd0 && q2.size() > 0;
    po4 = usb_slrd && usb_addr == 2'd1 && q4.size() > 0;
    po6 = host_ep6_ready && q6.size() > 0;
    po8 = host_ep8_ready && q8.size() > 0;
    uf = (usb_slrd && usb_addr == 2'd0 && q2.size() == 0) || (usb_slrd && usb_addr == 2'd1 && q4.size() == 0);
    of = (usb_slwr && usb_addr == 2'd2 && q6.size() == DEPTH) || (usb_slwr && usb_addr == 2'd3 && q8.size() == DEPTH);
    pr = (usb_slrd && usb_addr >= 2'd2) || (usb_slwr && usb_addr <= 2'd1);
    rst = reset;
    d2 = host_ep2_data;
    d4 = host_ep4_data;
    dw = usb_data_out;
    @(posedge clk);
    if (rst) begin
      q2.delete(); q4.delete(); q6.delete(); q8.delete();
      m_uf = 0; m_of = 0; m_pr = 0;
    end else begin
      if (po2) void'(q2.pop_front());
      if (po4) void'(q4.pop_front());
      if (po6) void'(q6.pop_front());
      if (po8) void'(q8.pop_front());
      if (pu2) q2.push_back(d2);
      if (pu4) q4.push_back(d4);
      if (pu6) q6.push_back(dw);
      if (pu8) q8.push_back(dw);
      m_uf = m_uf | uf;
      m_of = m_of | of;
      m_pr = m_pr | pr;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    usb_addr = 2'd2;
    usb_slwr = 1'b1;
    host_ep2_valid = 1'b1;
    host_ep2_data = 8'h55;
    cycle();
    cycle();
    usb_addr = 2'd0;
    usb_slwr = 1'b0;
    usb_sloe = 1'b1;
    #1;
    tests++;
    if ({usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full} !== 4'b1100) begin
      fails++; $display("FAIL reset_flags got %b exp 1100", {usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full});
    end
    tests++;
    if ({host_ep2_ready, host_ep4_ready, host_ep6_valid, host_ep8_valid} !== 4'b1100) begin
      fails++; $display("FAIL reset_handshake got %b exp 1100", {host_ep2_ready, host_ep4_ready, host_ep6_valid, host_ep8_valid});
    end
    tests++;
    if (usb_data_in !== 8'h00) begin
      fails++; $display("FAIL reset_data_in got %h exp 00", usb_data_in);
    end
    tests++;
    if ({err_underflow, err_overflow, err_protocol} !== 3'b000) begin
      fails++; $display("FAIL reset_errors got %b exp 000", {err_underflow, err_overflow, err_protocol});
    end
    idle();
    cycle();
    #1;
    tests++;
    if ({usb_ep2_empty, usb_ep6_full, host_ep2_ready, host_ep6_valid} !== 4'b1010) begin
      fails++; $display("FAIL after_reset_flags got %b exp 1010", {usb_ep2_empty, usb_ep6_full, host_ep2_ready, host_ep6_valid});
    end
  endtask

  task automatic test_ep2_read();
    idle();
    host_ep2_valid = 1'b1;
    host_ep2_data = 8'hA5;
    cycle();
    host_ep2_data = 8'h3C;
    cycle();
    host_ep2_valid = 1'b0;
    usb_addr = 2'd0;
    usb_sloe = 1'b1;
    usb_slrd = 1'b1;
    #1;
    tests++;
    if (usb_ep2_empty !== 1'b0 || usb_data_in !== 8'hA5) begin
      fails++; $display("FAIL ep2_first got empty=%b data=%h exp empty=0 data=a5", usb_ep2_empty, usb_data_in);
    end
    cycle();
    #1;
    tests++;
    if (usb_data_in !== 8'h3C) begin
      fails++; $display("FAIL ep2_second got %h exp 3c", usb_data_in);
    end
    cycle();
    usb_slrd = 1'b0;
    #1;
    tests++;
    if (usb_ep2_empty !== 1'b1 || usb_data_in !== 8'h00 || err_underflow !== 1'b0) begin
      fails++; $display("FAIL ep2_drained got empty=%b data=%h uf=%b exp 1 00 0", usb_ep2_empty, usb_data_in, err_underflow);
    end
  endtask

  task automatic test_ep6_fill();
    idle();
    usb_addr = 2'd2;
    usb_slwr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      usb_data_out = 8'(i);
      cycle();
    end
    #1;
    tests++;
    if (usb_ep6_full !== 1'b1 || host_ep6_valid !== 1'b1) begin
      fails++; $display("FAIL ep6_full got full=%b valid=%b exp 1 1", usb_ep6_full, host_ep6_valid);
    end
    usb_data_out = 8'hEE;
    cycle();
    #1;
    tests++;
    if (err_overflow !== 1'b1 || usb_ep6_full !== 1'b1) begin
      fails++; $display("FAIL ep6_overflow got ovf=%b full=%b exp 1 1", err_overflow, usb_ep6_full);
    end
    usb_slwr = 1'b0;
    host_ep6_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      tests++;
      if (host_ep6_valid !== 1'b1 || host_ep6_data !== 8'(i)) begin
        fails++; $display("FAIL ep6_pop[%0d] got valid=%b data=%h exp 1 %h", i, host_ep6_valid, host_ep6_data, 8'(i));
      end
      cycle();
    end
    host_ep6_ready = 1'b0;
    #1;
    tests++;
    if (host_ep6_valid !== 1'b0 || usb_ep6_full !== 1'b0) begin
      fails++; $display("FAIL ep6_drained got valid=%b full=%b exp 0 0", host_ep6_valid, usb_ep6_full);
    end
  endtask

  task automatic test_errors();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    usb_addr = 2'd1;
    usb_slrd = 1'b1;
    cycle();
    usb_slrd = 1'b0;
    #1;
    tests++;
    if ({err_underflow, err_overflow, err_protocol, usb_ep4_empty} !== 4'b1001) begin
      fails++; $display("FAIL underflow got %b exp 1001", {err_underflow, err_overflow, err_protocol, usb_ep4_empty});
    end
    usb_addr = 2'd0;
    usb_slwr = 1'b1;
    usb_data_out = 8'h77;
    cycle();
    usb_slwr = 1'b0;
    #1;
    tests++;
    if ({err_underflow, err_overflow, err_protocol, usb_ep2_empty} !== 4'b1011) begin
      fails++; $display("FAIL protocol got %b exp 1011", {err_underflow, err_overflow, err_protocol, usb_ep2_empty});
    end
  endtask

  task automatic test_ep8_simul();
    idle();
    usb_addr = 2'd3;
    usb_slwr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      usb_data_out = 8'(16 + i);
      cycle();
    end
    usb_data_out = 8'h15;
    host_ep8_ready = 1'b1;
    #1;
    tests++;
    if (host_ep8_valid !== 1'b1 || host_ep8_data !== 8'h10) begin
      fails++; $display("FAIL ep8_simul_head got valid=%b data=%h exp 1 10", host_ep8_valid, host_ep8_data);
    end
    cycle();
    usb_slwr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      tests++;
      if (host_ep8_valid !== 1'b1 || host_ep8_data !== 8'(16 + i)) begin
        fails++; $display("FAIL ep8_order[%0d] got valid=%b data=%h exp 1 %h", i, host_ep8_valid, host_ep8_data, 8'(16 + i));
      end
      cycle();
    end
    #1;
    tests++;
    if (host_ep8_valid !== 1'b0) begin
      fails++; $display("FAIL ep8_count got valid=%b exp 0 after 5 pops", host_ep8_valid);
    end
  endtask

  task automatic test_random();
    int prod, cons;
    logic [7:0] exp_di;
    logic [7:0] exp_fl;
    prod = 2;
    cons = 2;
    idle();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        prod = ($urandom_range(0, 1) != 0) ? 7 : 2;
        cons = ($urandom_range(0, 1) != 0) ? 7 : 2;
      end
      usb_addr = 2'($urandom_range(0, 3));
      usb_sloe = 1'($urandom_range(0, 1));
      usb_slrd = $urandom_range(0, 7) < cons;
      usb_slwr = $urandom_range(0, 7) < prod;
      usb_data_out = 8'($urandom);
      host_ep2_valid = $urandom_range(0, 7) < prod;
      host_ep4_valid = $urandom_range(0, 7) < prod;
      host_ep2_data = 8'($urandom);
      host_ep4_data = 8'($urandom);
      host_ep6_ready = $urandom_range(0, 7) < cons;
      host_ep8_ready = $urandom_range(0, 7) < cons;
      #1;
      exp_di = 8'h00;
      if (usb_sloe && usb_addr == 2'd0 && q2.size() > 0) exp_di = q2[0];
      if (usb_sloe && usb_addr == 2'd1 && q4.size() > 0) exp_di = q4[0];
      exp_fl = {q2.size() == 0, q4.size() == 0, q6.size() == DEPTH, q8.size() == DEPTH,
                q2.size() < DEPTH, q4.size() < DEPTH, q6.size() > 0, q8.size() > 0};
      tests++;
      if (usb_data_in !== exp_di) begin
        fails++; $display("FAIL rand_data_in[%0d] got %h exp %h", c, usb_data_in, exp_di);
      end
      tests++;
      if ({usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
           host_ep2_ready, host_ep4_ready, host_ep6_valid, host_ep8_valid} !== exp_fl) begin
        fails++; $display("FAIL rand_flags[%0d] got %b exp %b", c, {usb_ep2_empty, usb_ep4_empty, usb_ep6_full,
          usb_ep8_full, host_ep2_ready, host_ep4_ready, host_ep6_valid, host_ep8_valid}, exp_fl);
      end
      tests++;
      if ({err_underflow, err_overflow, err_protocol} !== {m_uf, m_of, m_pr}) begin
        fails++; $display("FAIL rand_errors[%0d] got %b exp %b", c, {err_underflow, err_overflow, err_protocol}, {m_uf, m_of, m_pr});
      end
      if (q6.size() > 0) begin
        tests++;
        if (host_ep6_data !== q6[0]) begin
          fails++; $display("FAIL rand_ep6_data[%0d] got %h exp %h", c, host_ep6_data, q6[0]);
        end
      end
      if (q8.size() > 0) begin
        tests++;
        if (host_ep8_data !== q8[0]) begin
          fails++; $display("FAIL rand_ep8_data[%0d] got %h exp %h", c, host_ep8_data, q8[0]);
        end
      end
      cycle();
    end
  endtask

  task automatic test_reset_midburst();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    usb_addr = 2'd2;
    usb_slwr = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      usb_data_out = 8'($urandom);
      host_ep2_valid = i < 100;
      host_ep2_data = 8'($urandom);
      cycle();
    end
    host_ep2_valid = 1'b0;
    usb_slrd = 1'b1;
    cycle();
    #1;
    tests++;
    if ({usb_ep2_empty, usb_ep6_full, err_underflow, err_overflow, err_protocol} !== 5'b01011 || q2.size() != 100) begin
      fails++; $display("FAIL midburst_pre got %b exp 01011", {usb_ep2_empty, usb_ep6_full, err_underflow, err_overflow, err_protocol});
    end
    reset = 1'b1;
    host_ep2_valid = 1'b1;
    host_ep6_ready = 1'b1;
    cycle();
    #1;
    tests++;
    if ({usb_ep2_empty, usb_ep6_full, err_underflow, err_overflow, err_protocol, host_ep2_ready, host_ep6_valid} !== 7'b1000010) begin
      fails++; $display("FAIL midburst_reset got %b exp 1000010",
        {usb_ep2_empty, usb_ep6_full, err_underflow, err_overflow, err_protocol, host_ep2_ready, host_ep6_valid});
    end
    idle();
    cycle();
  endtask

  initial begin
    idle();
    test_reset();
    test_ep2_read();
    test_ep6_fill();
    test_errors();
    test_ep8_simul();
    test_random();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
